// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the register-bank bus.
// Imported by the arbiter top and its helpers.
package reg_bus_pkg;

    localparam int ADDR_W     = 16;
    localparam int SUB_ADDR_W = 12;
    localparam int DATA_W     = 32;
    localparam int SEL_LSB    = 12;

    localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request above last_gnt,
// wrapping around. Reusable by other bus blocks.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_gnt,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx
);

    // Scan N slots starting just after the previous winner.
    always_comb begin
        int  idx;
        logic found;
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_gnt) + k) % N;
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter for the register-bank bus: grant, decode,
// one-cycle sub-block access, then a one-cycle ack to the winner.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int                NREQ      = 2,
    parameter int                NSUB      = 4,
    parameter logic [DATA_W-1:0] ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ack,
    output logic [DATA_W-1:0]        resp_rdata,
    output logic                     resp_err,
    output logic [NSUB-1:0]          sub_wr_en,
    output logic [SUB_ADDR_W-1:0]    sub_reg_addr,
    output logic [DATA_W-1:0]        reg_wr_data,
    input  logic [NSUB*DATA_W-1:0]   sub_rd_data
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e              state_q, state_d;
    logic [IW-1:0]       last_gnt_q, last_gnt_d;
    logic [IW-1:0]       gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [NREQ-1:0]     arb_oh;
    logic [IW-1:0]       arb_idx;
    logic [3:0]          sel;
    logic                acc_err;
    logic [DATA_W-1:0]   rd_word;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr (
        .req      (req_valid),
        .last_gnt (last_gnt_q),
        .gnt_oh   (arb_oh),
        .gnt_idx  (arb_idx)
    );

    assign sel     = addr_q[ADDR_W-1:SEL_LSB];
    assign acc_err = !((32'(sel) < 32'(NSUB)) && (addr_q[1:0] == 2'b00));

    assign resp_rdata   = rdata_q;
    assign resp_err     = err_q;
    assign sub_reg_addr = addr_q[SUB_ADDR_W-1:0];
    assign reg_wr_data  = wdata_q;

    // Read-data mux over the selected sub-block.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NSUB; i++) begin
            if (32'(sel) == 32'(i)) begin
                rd_word = sub_rd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= IW'(NREQ - 1);
            gnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Next-state, strobe and ack generation.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        sub_wr_en  = '0;
        req_ack    = '0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    gnt_d   = arb_idx;
                    state_d = ACCESS;
                    for (int i = 0; i < NREQ; i++) begin
                        if (arb_oh[i]) begin
                            we_d    = req_we[i];
                            addr_d  = req_addr[i*ADDR_W +: ADDR_W];
                            wdata_d = req_wdata[i*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            ACCESS: begin
                for (int i = 0; i < NSUB; i++) begin
                    sub_wr_en[i] = we_q && !acc_err && (32'(sel) == 32'(i));
                end
                if (acc_err) begin
                    rdata_d = ERR_RDATA;
                end else if (we_q) begin
                    rdata_d = '0;
                end else begin
                    rdata_d = rd_word;
                end
                err_d   = acc_err;
                state_d = RESP;
            end
            RESP: begin
                for (int i = 0; i < NREQ; i++) begin
                    req_ack[i] = (32'(gnt_q) == 32'(i));
                end
                last_gnt_d = gnt_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter with a small register-bank
// model behind the sub-block ports.
module tb_reg_bus_arbiter;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_we;
    logic [31:0]  req_addr;
    logic [63:0]  req_wdata;
    logic [1:0]   req_ack;
    logic [31:0]  resp_rdata;
    logic         resp_err;
    logic [3:0]   sub_wr_en;
    logic [11:0]  sub_reg_addr;
    logic [31:0]  reg_wr_data;
    logic [127:0] sub_rd_data;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] rdata;
        logic        err;
    } ack_t;

    typedef struct packed {
        logic [3:0]  en;
        logic [11:0] addr;
        logic [31:0] data;
    } stb_t;

    ack_t ack_q[$];
    stb_t stb_q[$];

    logic [31:0] bank [4][16];

    reg_bus_arbiter #(
        .NREQ      (2),
        .NSUB      (4),
        .ERR_RDATA (32'hDEAD_BEEF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ack      (req_ack),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .sub_wr_en    (sub_wr_en),
        .sub_reg_addr (sub_reg_addr),
        .reg_wr_data  (reg_wr_data),
        .sub_rd_data  (sub_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        sub_rd_data = '0;
        for (int s = 0; s < 4; s++) begin
            sub_rd_data[s*32 +: 32] = bank[s][sub_reg_addr[5:2]];
        end
    end

    always @(posedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (sub_wr_en[s]) bank[s][sub_reg_addr[5:2]] <= reg_wr_data;
        end
    end

    // Monitor: pops expectations whenever the DUT strobes or acks.
    always @(negedge clk) begin
        ack_t ea;
        stb_t es;
        int   id;
        if (|sub_wr_en || |req_ack) begin
            checks++;
            if (|sub_wr_en && |req_ack) begin
                errors++;
                $display("FAIL overlap: wr_en=%b ack=%b, required not both", sub_wr_en, req_ack);
            end
        end
        if (|sub_wr_en) begin
            checks++;
            if (stb_q.size() == 0) begin
                errors++;
                $display("FAIL strobe: unexpected wr_en=%b addr=%h", sub_wr_en, sub_reg_addr);
            end else begin
                es = stb_q.pop_front();
                if (sub_wr_en !== es.en || sub_reg_addr !== es.addr || reg_wr_data !== es.data) begin
                    errors++;
                    $display("FAIL strobe: got en=%b addr=%h data=%h, required en=%b addr=%h data=%h",
                             sub_wr_en, sub_reg_addr, reg_wr_data, es.en, es.addr, es.data);
                end
            end
        end
        if (|req_ack) begin
            checks++;
            id = (req_ack == 2'b10) ? 1 : (req_ack == 2'b01) ? 0 : -1;
            if (ack_q.size() == 0) begin
                errors++;
                $display("FAIL ack: unexpected ack=%b", req_ack);
            end else begin
                ea = ack_q.pop_front();
                if (id != int'(ea.id) || resp_rdata !== ea.rdata || resp_err !== ea.err) begin
                    errors++;
                    $display("FAIL ack: got id=%0d rdata=%h err=%b, required id=%0d rdata=%h err=%b",
                             id, resp_rdata, resp_err, ea.id, ea.rdata, ea.err);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if (req_ack !== 0 || sub_wr_en !== 0 || resp_rdata !== 0 || resp_err !== 0 ||
            sub_reg_addr !== 0 || reg_wr_data !== 0) begin
            errors++;
            $display("FAIL %s: ack=%b en=%b rd=%h err=%b sa=%h wd=%h, required all 0",
                     name, req_ack, sub_wr_en, resp_rdata, resp_err, sub_reg_addr, reg_wr_data);
        end
    endtask

    task automatic wait_ack(input int id, output int n, output bit got);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (req_ack[id]) got = 1'b1;
        end
    endtask

    task automatic do_req(input int id, input logic we, input logic [15:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err, input logic [3:0] exp_en,
                          input bit glitch);
        int n;
        bit got;
        ack_q.push_back('{32'(id), exp_rd, exp_err});
        if (exp_en != 0) stb_q.push_back('{exp_en, addr[11:0], wd});
        req_valid[id]            = 1'b1;
        req_we[id]               = we;
        req_addr[id*16 +: 16]    = addr;
        req_wdata[id*32 +: 32]   = wd;
        if (glitch) begin
            @(posedge clk);
            #1;
            req_addr[id*16 +: 16]  = ~addr;
            req_wdata[id*32 +: 32] = ~wd;
        end
        wait_ack(id, n, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL latency: req%0d addr=%h no ack in 20 cycles", id, addr);
        end else if (n != (glitch ? 2 : 3)) begin
            errors++;
            $display("FAIL latency: req%0d addr=%h ack after %0d, required %0d",
                     id, addr, n, glitch ? 2 : 3);
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  got;
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then read back sub-block 2.
        do_req(0, 1'b1, 16'h2004, 32'h1234_5678, 32'h0, 1'b0, 4'b0100, 1'b0);
        do_req(0, 1'b0, 16'h2004, 32'h0, 32'h1234_5678, 1'b0, 4'b0000, 1'b0);
        // Decode errors.
        do_req(1, 1'b0, 16'h5000, 32'h0, 32'hDEAD_BEEF, 1'b1, 4'b0000, 1'b0);
        do_req(0, 1'b1, 16'h0002, 32'h5555_AAAA, 32'hDEAD_BEEF, 1'b1, 4'b0000, 1'b0);
        // Plain write on requester 1.
        do_req(1, 1'b1, 16'h1008, 32'hAAAA_5555, 32'h0, 1'b0, 4'b0010, 1'b0);
        // Inputs change during ACCESS; original sample must be used.
        do_req(1, 1'b1, 16'h3010, 32'hCAFE_0001, 32'h0, 1'b0, 4'b1000, 1'b1);
        do_req(0, 1'b0, 16'h3010, 32'h0, 32'hCAFE_0001, 1'b0, 4'b0000, 1'b1);

        // Reset in the middle of a write access.
        req_valid[0]     = 1'b1;
        req_we[0]        = 1'b1;
        req_addr[15:0]   = 16'h2008;
        req_wdata[31:0]  = 32'h1111_1111;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        do_req(0, 1'b1, 16'h2008, 32'h1111_1111, 32'h0, 1'b0, 4'b0100, 1'b0);
        do_req(1, 1'b0, 16'h2008, 32'h0, 32'h1111_1111, 1'b0, 4'b0000, 1'b0);

        // Requester 1 streams five back-to-back reads.
        for (int t = 0; t < 5; t++) ack_q.push_back('{32'd1, 32'hAAAA_5555, 1'b0});
        req_valid[1]      = 1'b1;
        req_we[1]         = 1'b0;
        req_addr[31:16]   = 16'h1008;
        for (int t = 0; t < 5; t++) begin
            wait_ack(1, n, got);
            checks++;
            if (!got || n != 3) begin
                errors++;
                $display("FAIL stream: ack %0d after %0d cycles (got=%0b), required 3", t, n, got);
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;

        // Contention from reset: grants alternate 0,1,0,1.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_we          = 2'b00;
        req_addr[15:0]  = 16'h2004;
        req_addr[31:16] = 16'h1008;
        req_valid       = 2'b11;
        ack_q.push_back('{32'd0, 32'h1234_5678, 1'b0});
        ack_q.push_back('{32'd1, 32'hAAAA_5555, 1'b0});
        ack_q.push_back('{32'd0, 32'h1234_5678, 1'b0});
        ack_q.push_back('{32'd1, 32'hAAAA_5555, 1'b0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            n   = 0;
            got = 1'b0;
            while (!got && n < 20) begin
                @(negedge clk);
                n++;
                if (|req_ack) got = 1'b1;
            end
            checks++;
            if (!got || n != ((t == 0) ? 2 : 3)) begin
                errors++;
                $display("FAIL contend: ack %0d after %0d cycles (got=%0b), required %0d",
                         t, n, got, (t == 0) ? 2 : 3);
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (4) @(posedge clk);

        checks++;
        if (ack_q.size() != 0 || stb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d acks and %0d strobes still pending, required 0",
                     ack_q.size(), stb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
